// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 SPI host and the SSD1306 raster model.
package ssd1306_pkg;

  typedef enum logic [2:0] {
    StRstLow,
    StRstWait,
    StIdle,
    StSetup,
    StShift,
    StHold
  } state_e;

  // SSD1306 opcodes shared with the raster model.
  localparam logic [7:0] OpDisplayOff  = 8'hAE;
  localparam logic [7:0] OpDisplayOn   = 8'hAF;
  localparam logic [7:0] OpAddrMode    = 8'h20;
  localparam logic [7:0] OpColumnRange = 8'h21;
  localparam logic [7:0] OpPageRange   = 8'h22;
  localparam logic [7:0] OpChargePump  = 8'h8D;

  // Bits needed for a counter reaching max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ssd1306_spi_shifter.sv
// SCL half-period divider, bit counter and MSB-first MOSI shifter (CPOL=0).
module ssd1306_spi_shifter #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       run,
  output logic       scl,
  output logic       mosi,
  output logic       half_done,
  output logic       last_bit
);
  import ssd1306_pkg::*;

  localparam int unsigned DivW = cnt_width(CLK_DIV);

  logic [DivW-1:0] div_q;
  logic [7:0]      sreg_q;
  logic [2:0]      bit_q;
  logic            scl_q;

  assign half_done = (div_q == DivW'(CLK_DIV - 1));
  // Bit 0's high phase is ending; the next edge is its falling edge.
  assign last_bit  = half_done & scl_q & (bit_q == 3'd7);
  assign scl       = scl_q;
  assign mosi      = sreg_q[7];

  // Divider, bit counter and shift register; a load restarts a byte with SCL low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      sreg_q <= '0;
      bit_q  <= '0;
      scl_q  <= 1'b0;
    end else if (clear) begin
      div_q  <= '0;
      sreg_q <= '0;
      bit_q  <= '0;
      scl_q  <= 1'b0;
    end else if (load) begin
      div_q  <= '0;
      sreg_q <= load_data;
      bit_q  <= '0;
      scl_q  <= 1'b0;
    end else if (run) begin
      if (half_done) begin
        div_q <= '0;
        scl_q <= ~scl_q;
        if (scl_q) begin
          // Falling edge: present the next bit, zeros fill so MOSI idles low.
          sreg_q <= {sreg_q[6:0], 1'b0};
          if (bit_q != 3'd7) bit_q <= bit_q + 3'd1;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_host.sv
// SSD1306 4-wire SPI initiator: panel reset sequence, byte holding register, CS framing.
module ssd1306_spi_host #(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned RST_LOW_CYCLES  = 160,
  parameter int unsigned RST_WAIT_CYCLES = 1600,
  parameter int unsigned CS_HOLD_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_req,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_dc,
  output logic       init_done,
  output logic       busy,
  output logic       oled_rst,
  output logic       oled_cs,
  output logic       oled_dc,
  output logic       spi_scl,
  output logic       spi_mosi
);
  import ssd1306_pkg::*;

  localparam int unsigned RstMax = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES
                                                                       : RST_WAIT_CYCLES;
  localparam int unsigned RstW   = cnt_width(RstMax);
  localparam int unsigned HoldW  = cnt_width(CS_HOLD_CYCLES);

  state_e           state_q, state_d;
  logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             init_done_q, init_done_d;
  logic             cs_q, cs_d;
  logic             dc_q, dc_d;
  logic             full_q;
  logic [7:0]       hold_data_q;
  logic             hold_dc_q;
  logic             handshake;
  logic             load, clear, run;
  logic             half_done, last_bit;

  assign in_ready  = init_done_q & ~full_q;
  assign handshake = in_valid & in_ready;
  assign init_done = init_done_q;
  assign busy      = ((state_q != StIdle) & init_done_q) | full_q;
  assign oled_rst  = (state_q != StRstLow);
  assign oled_cs   = cs_q;
  assign oled_dc   = dc_q;

  ssd1306_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .load_data (hold_data_q),
    .run       (run),
    .scl       (spi_scl),
    .mosi      (spi_mosi),
    .half_done (half_done),
    .last_bit  (last_bit)
  );

  // One-entry holding register; a new handshake wins over a same-cycle load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= 1'b0;
      hold_data_q <= '0;
      hold_dc_q   <= 1'b0;
    end else if (reset_req) begin
      full_q <= 1'b0;
    end else if (handshake) begin
      full_q      <= 1'b1;
      hold_data_q <= in_data;
      hold_dc_q   <= in_dc;
    end else if (load) begin
      full_q <= 1'b0;
    end
  end

  // FSM next state, counters, CS/DC and shifter controls.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    init_done_d = init_done_q;
    cs_d        = cs_q;
    dc_d        = dc_q;
    load        = 1'b0;
    clear       = 1'b0;
    run         = 1'b0;
    if (reset_req) begin
      state_d     = StRstLow;
      rst_cnt_d   = '0;
      hold_cnt_d  = '0;
      init_done_d = 1'b0;
      cs_d        = 1'b1;
      clear       = 1'b1;
    end else begin
      case (state_q)
        StRstLow: begin
          if (rst_cnt_q >= RstW'(RST_LOW_CYCLES - 1)) begin
            state_d   = StRstWait;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        StRstWait: begin
          if (rst_cnt_q >= RstW'(RST_WAIT_CYCLES - 1)) begin
            state_d     = StIdle;
            rst_cnt_d   = '0;
            init_done_d = 1'b1;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        StIdle: begin
          cs_d = 1'b1;
          if (full_q) begin
            load    = 1'b1;
            cs_d    = 1'b0;
            dc_d    = hold_dc_q;
            state_d = StSetup;
          end
        end
        StSetup: begin
          // First low phase; the shifter raises SCL as we leave.
          run = 1'b1;
          if (half_done) state_d = StShift;
        end
        StShift: begin
          run = 1'b1;
          if (last_bit) begin
            if (full_q) begin
              // Back-to-back: reload on bit 0's falling edge, no gap.
              load = 1'b1;
              dc_d = hold_dc_q;
            end else begin
              state_d    = StHold;
              hold_cnt_d = '0;
            end
          end
        end
        StHold: begin
          if (full_q) begin
            load       = 1'b1;
            dc_d       = hold_dc_q;
            state_d    = StSetup;
            hold_cnt_d = '0;
          end else if (int'(hold_cnt_q) + 1 >= int'(CS_HOLD_CYCLES)) begin
            cs_d       = 1'b1;
            state_d    = StIdle;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        default: state_d = StRstLow;
      endcase
    end
  end

  // FSM state and registered panel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRstLow;
      rst_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      init_done_q <= 1'b0;
      cs_q        <= 1'b1;
      dc_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      init_done_q <= init_done_d;
      cs_q        <= cs_d;
      dc_q        <= dc_d;
    end
  end

endmodule

// File: doc/ssd1306_spi_host.md
Name: ssd1306_spi_host

Overview:
- Initiator side of the SSD1306 4-wire SPI link: takes command/data bytes from a valid/ready stream and drives SCL, MOSI, DC and CS into an SSD1306 panel or into our own SSD1306 raster model.
- Generates the power-up OLED reset pulse and manages CS framing across back-to-back bytes.
- Lets a soft core or hardware framebuffer walker drive a physical OLED without a CPU-side SPI peripheral.

Parameters:
- CLK_DIV, 2: system clocks per SCL half-period, minimum 1. At 16 MHz, 2 gives 4 MHz SCL.
- RST_LOW_CYCLES, 160: clocks with oled_rst held low after reset or reset_req; minimum 1.
- RST_WAIT_CYCLES, 1600: clocks with oled_rst high before init_done; minimum 1.
- CS_HOLD_CYCLES, 8: idle clocks CS stays low after the last byte waiting for more; 0 means release immediately.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- reset_req  in  1  one-cycle pulse: abort traffic, redo the OLED reset sequence
- in_valid  in  1  byte available
- in_ready  out  1  byte accepted when in_valid & in_ready
- in_data  in  8  byte to send, MSB first
- in_dc  in  1  0 = command, 1 = data
- init_done  out  1  reset sequence complete
- busy  out  1  transfer pending or CS asserted
- oled_rst  out  1  panel reset, active low
- oled_cs  out  1  chip select, active low
- oled_dc  out  1  D/C# line
- spi_scl  out  1  SPI clock, CPOL=0
- spi_mosi  out  1  SPI data, changes while SCL is low

Behaviour:
- Reset values (rst low): oled_rst=0, oled_cs=1, spi_scl=0, spi_mosi=0, oled_dc=0, in_ready=0, init_done=0, busy=0, holding register empty, state RST_LOW, all counters 0.
- Holding register: one entry (data, dc, full flag).
  - in_ready = init_done & ~full.
  - A handshake sets full on the next edge.
  - full clears on the cycle the shifter loads it. A load and a new handshake in the same cycle are legal; the net result is full=1 with the new byte.
- FSM states:
  - RST_LOW: oled_rst=0 for RST_LOW_CYCLES, then go to RST_WAIT.
  - RST_WAIT: oled_rst=1 for RST_WAIT_CYCLES, then set init_done=1 and go to IDLE.
  - IDLE: cs=1, scl=0. If full, load the shifter, drive cs=0, dc=held dc, mosi=bit7, and go to SETUP.
  - SETUP: hold for CLK_DIV cycles with scl=0, then go to SHIFT.
  - SHIFT: each bit is CLK_DIV cycles with scl=1 followed by CLK_DIV cycles with scl=0.
    - mosi advances to the next bit on the cycle scl falls.
    - After bit0's high phase, if full: load the next byte, update dc and mosi on that same falling cycle, and stay in SHIFT. Back-to-back byte period is exactly 16*CLK_DIV clocks.
    - Otherwise go to HOLD with scl=0.
  - HOLD: cs stays low.
    - If full arrives, reload and go to SETUP.
    - After CS_HOLD_CYCLES with no byte, drive cs=1 and go to IDLE.
    - With CS_HOLD_CYCLES=0, HOLD lasts one cycle.
- Timing from IDLE: handshake at cycle T, full at T+1, cs falls at T+2, first SCL rise at T+2+CLK_DIV.
- busy = (state not IDLE and init_done) | full.
- reset_req (only sampled when rst is high) takes priority over everything:
  - Next edge: state RST_LOW, cs=1, scl=0, mosi=0, full cleared, partial byte discarded, init_done=0.
  - A pulse during RST_LOW restarts the count.
- dc is only changed while scl is low; the SSD1306 samples it with bit0.
- Counters are sized $clog2(max param + 1) and saturate; they never wrap.

Decomposition:
- Shared package ssd1306_pkg holds:
  - FSM state encodings (RST_LOW, RST_WAIT, IDLE, SETUP, SHIFT, HOLD).
  - SSD1306 opcode constants: 8'hAE display off, 8'hAF display on, 8'h20 addressing mode, 8'h21 column range, 8'h22 page range, 8'h8D charge pump. These are shared with the ssd1306 raster model.
- One natural sub-module, ssd1306_spi_shifter: bit counter, half-period divider, SCL/MOSI generation, with a load/last_bit handshake to the top FSM.

Test Plan:
- Reset release, CLK_DIV=2: oled_rst low exactly 160 clocks, high for 1600 clocks, then init_done=1 and in_ready=1; cs, scl and mosi idle at 1, 0, 0 throughout.
- Single command 8'hAE, dc=0: cs falls T+2, exactly 8 SCL rises with MOSI sampled 1,0,1,0,1,1,1,0 on each rise and dc=0 at every rise; cs rises 8 clocks after the last fall.
- Stream 8'h21 (dc=0) then 8'hFF, 8'h00 (dc=1) with in_valid held high:
  - SCL period is 4 clocks, no gap between bytes, and cs stays low throughout.
  - dc toggles to 1 while SCL is low before the second byte's first rise.
  - The model receives the bytes in order.
- Byte arriving during HOLD, 3 clocks after the last fall: no cs deassert, SETUP of 2 clocks, then transfer.
- reset_req asserted mid-byte after the 3rd SCL rise: next edge gives cs=1, scl=0, oled_rst=0, init_done=0; full reset sequence repeats; the partial byte is never completed.
- CLK_DIV=1, CS_HOLD_CYCLES=0, 128 data bytes: total 2048 SCL half-periods, cs released exactly 1 clock after the final fall, and in_ready is never high while full.
